// File: rtl/keypad_scan_ctrl.sv
// Row-scan sequencer for a 4x4 active-low matrix keypad feeding a key debouncer.
// Define MULTI_KEY_REJECT_EN to ignore samples with more than one column low.
module keypad_scan_ctrl #(
   parameter int unsigned SETTLE_CYCLES  = 300,
   parameter int unsigned RELEASE_CYCLES = 3000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic       key_pressed,
   output logic [3:0] row_idx,
   output logic [3:0] col_idx,
   input  logic       key_valid,
   output logic       key_event,
   output logic [3:0] key_code,
   output logic       scanning
);

   typedef enum logic [1:0] {
      SCAN_DRIVE,
      SCAN_SAMPLE,
      LOCK,
      RELEASE
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

   state_t           state;
   logic [3:0]       col_s1;
   logic [3:0]       col_s;
   logic [1:0]       row_ptr;
   logic [1:0]       row_nxt;
   logic [1:0]       lock_col;
   logic [1:0]       low_col;
   logic             any_low;
   logic             press_ok;
   logic             found;
   logic [CNT_W-1:0] settle_cnt;
   logic [CNT_W-1:0] release_cnt;
   logic             event_done;
`ifdef MULTI_KEY_REJECT_EN
   logic [2:0]       n_low;
`endif

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
         4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
         4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
         4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
      endcase
      return code;
   endfunction

   // Lowest-index low column wins; optionally count lows for multi-key rejection.
   always_comb begin
      low_col = '0;
      found   = 1'b0;
`ifdef MULTI_KEY_REJECT_EN
      n_low   = '0;
`endif
      for (int unsigned i = 0; i < 4; i++) begin
         if (!col_s[i] && !found) begin
            low_col = 2'(i);
            found   = 1'b1;
         end
`ifdef MULTI_KEY_REJECT_EN
         n_low = n_low + {2'b00, ~col_s[i]};
`endif
      end
      any_low = (col_s != 4'hF);
`ifdef MULTI_KEY_REJECT_EN
      press_ok = any_low && (n_low == 3'd1);
`else
      press_ok = any_low;
`endif
      row_nxt = row_ptr + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= SCAN_DRIVE;
         col_s1      <= '1;
         col_s       <= '1;
         row_ptr     <= '0;
         row_n       <= 4'b1110;
         lock_col    <= '0;
         settle_cnt  <= '0;
         release_cnt <= '0;
         event_done  <= 1'b0;
         key_pressed <= 1'b0;
         row_idx     <= '0;
         col_idx     <= '0;
         key_event   <= 1'b0;
         key_code    <= '0;
         scanning    <= 1'b1;
      end else begin
         col_s1    <= col_n;
         col_s     <= col_s1;
         key_event <= 1'b0;
         case (state)
            SCAN_DRIVE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= '0;
                  state      <= SCAN_SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            SCAN_SAMPLE: begin
               if (press_ok) begin
                  state       <= LOCK;
                  lock_col    <= low_col;
                  row_idx     <= 4'b0001 << row_ptr;
                  col_idx     <= 4'b0001 << low_col;
                  key_pressed <= 1'b1;
                  scanning    <= 1'b0;
                  release_cnt <= '0;
               end else begin
                  row_ptr <= row_nxt;
                  row_n   <= ~(4'b0001 << row_nxt);
                  state   <= SCAN_DRIVE;
               end
            end
            LOCK: begin
               // Bounces drop key_pressed so the debouncer restarts its qualification.
               key_pressed <= ~col_s[lock_col];
               if (col_s[lock_col]) begin
                  if (release_cnt == RELEASE_LAST) begin
                     release_cnt <= '0;
                     state       <= RELEASE;
                  end else begin
                     release_cnt <= release_cnt + 1'b1;
                  end
               end else begin
                  release_cnt <= '0;
               end
               if (key_valid && !event_done) begin
                  key_event  <= 1'b1;
                  key_code   <= key_map(row_ptr, lock_col);
                  event_done <= 1'b1;
               end
            end
            RELEASE: begin
               key_pressed <= 1'b0;
               row_idx     <= '0;
               col_idx     <= '0;
               event_done  <= 1'b0;
               row_ptr     <= row_nxt;
               row_n       <= ~(4'b0001 << row_nxt);
               scanning    <= 1'b1;
               state       <= SCAN_DRIVE;
            end
            default: state <= SCAN_DRIVE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl with a behavioural keypad matrix model.
module tb_keypad_scan_ctrl;

   localparam int unsigned SETTLE = 4;
   localparam int unsigned REL    = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic       key_pressed;
   logic [3:0] row_idx;
   logic [3:0] col_idx;
   logic       key_valid;
   logic       key_event;
   logic [3:0] key_code;
   logic       scanning;

   logic [3:0] key_mask [4];
   logic [3:0] exp_q [$];
   logic [3:0] exp_code;
   int         checks   = 0;
   int         failures = 0;
   int         events   = 0;

   keypad_scan_ctrl #(
      .SETTLE_CYCLES (SETTLE),
      .RELEASE_CYCLES(REL),
      .CNT_W         (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .col_n      (col_n),
      .row_n      (row_n),
      .key_pressed(key_pressed),
      .row_idx    (row_idx),
      .col_idx    (col_idx),
      .key_valid  (key_valid),
      .key_event  (key_event),
      .key_code   (key_code),
      .scanning   (scanning)
   );

   always #5 clk = ~clk;

   // Pressed switches connect the driven (low) row to their columns.
   always_comb begin
      col_n = 4'hF;
      for (int i = 0; i < 4; i++) begin
         if (row_n[i] == 1'b0) col_n = ~key_mask[i];
      end
   end

   always @(negedge clk) begin
      if (key_event === 1'b1) begin
         events++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got key_code=%h, required no event", key_code);
         end else begin
            exp_code = exp_q.pop_front();
            if (key_code !== exp_code) begin
               failures++;
               $display("FAIL event_key_code got %h, required %h", key_code, exp_code);
            end
         end
      end
   end

   task automatic wait_scan(input logic want, input int unsigned bound, output bit ok);
      ok = 1'b0;
      for (int unsigned i = 0; i < bound && !ok; i++) begin
         @(negedge clk);
         if (scanning === want) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      key_valid = 1'b0;
      for (int i = 0; i < 4; i++) key_mask[i] = 4'h0;
      repeat (3) @(negedge clk);
      checks++;
      if ({row_n, key_pressed, row_idx, col_idx, key_event, key_code, scanning} !==
          {4'b1110, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1}) begin
         failures++;
         $display("FAIL reset_outputs got %b, required %b",
                  {row_n, key_pressed, row_idx, col_idx, key_event, key_code, scanning},
                  {4'b1110, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_idle_scan;
      logic [3:0] exp_row;
      for (int k = 0; k <= 20; k++) begin
         exp_row = ~(4'b0001 << ((k / 5) % 4));
         checks++;
         if ({row_n, scanning, key_pressed} !== {exp_row, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL idle_scan k=%0d got row_n=%b scanning=%b key_pressed=%b, required row_n=%b 1 0",
                     k, row_n, scanning, key_pressed, exp_row);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_press_row1;
      bit ok;
      int ev0;
      key_mask[1] = 4'b0010;
      wait_scan(1'b0, 200, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL press_row1_lock got timeout, required lock");
      end
      checks++;
      if ({row_n, row_idx, col_idx, key_pressed} !== {4'b1101, 4'b0010, 4'b0010, 1'b1}) begin
         failures++;
         $display("FAIL press_row1_fields got %b, required %b",
                  {row_n, row_idx, col_idx, key_pressed}, {4'b1101, 4'b0010, 4'b0010, 1'b1});
      end
      ev0 = events;
      exp_q.push_back(4'h5);
      key_valid = 1'b1;
      repeat (100) @(negedge clk);
      key_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (events - ev0 != 1) begin
         failures++;
         $display("FAIL press_row1_event_count got %0d, required 1", events - ev0);
      end
      checks++;
      if (key_code !== 4'h5) begin
         failures++;
         $display("FAIL press_row1_code_hold got %h, required 5", key_code);
      end
   endtask

   task automatic test_bounce;
      bit saw_low = 1'b0;
      bit left    = 1'b0;
      int ev0     = events;
      key_mask[1] = 4'b0000;
      repeat (5) begin
         @(negedge clk);
         if (key_pressed === 1'b0) saw_low = 1'b1;
         if (scanning !== 1'b0) left = 1'b1;
      end
      key_mask[1] = 4'b0010;
      repeat (6) begin
         @(negedge clk);
         if (scanning !== 1'b0) left = 1'b1;
      end
      checks++;
      if (!saw_low) begin
         failures++;
         $display("FAIL bounce_drop got key_pressed stuck 1, required a 0");
      end
      checks++;
      if (left) begin
         failures++;
         $display("FAIL bounce_stays_locked got scanning=1, required 0");
      end
      checks++;
      if (key_pressed !== 1'b1) begin
         failures++;
         $display("FAIL bounce_repress got key_pressed=%b, required 1", key_pressed);
      end
      key_valid = 1'b1;
      repeat (10) @(negedge clk);
      key_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (events != ev0) begin
         failures++;
         $display("FAIL bounce_no_event got %0d events, required 0", events - ev0);
      end
   endtask

   task automatic test_release;
      bit ok;
      key_mask[1] = 4'b0000;
      repeat (REL - 1) @(negedge clk);
      checks++;
      if (scanning !== 1'b0) begin
         failures++;
         $display("FAIL release_too_early got scanning=%b, required 0", scanning);
      end
      wait_scan(1'b1, 20, ok);
      checks++;
      if (!ok || {row_n, row_idx, col_idx, key_pressed} !== {4'b1011, 4'h0, 4'h0, 1'b0}) begin
         failures++;
         $display("FAIL release_resume got ok=%0d fields=%b, required 1 %b",
                  ok, {row_n, row_idx, col_idx, key_pressed}, {4'b1011, 4'h0, 4'h0, 1'b0});
      end
   endtask

   task automatic press_key(input int r, input int c, input logic [3:0] code);
      bit ok;
      int ev0;
      logic [3:0] er;
      logic [3:0] ec;
      er = 4'b0001 << r;
      ec = 4'b0001 << c;
      key_mask[r] = ec;
      wait_scan(1'b0, 200, ok);
      checks++;
      if (!ok || row_idx !== er || col_idx !== ec) begin
         failures++;
         $display("FAIL press_r%0dc%0d_lock got ok=%0d row_idx=%b col_idx=%b, required 1 %b %b",
                  r, c, ok, row_idx, col_idx, er, ec);
      end
      ev0 = events;
      exp_q.push_back(code);
      key_valid = 1'b1;
      repeat (3) @(negedge clk);
      key_valid   = 1'b0;
      key_mask[r] = 4'h0;
      wait_scan(1'b1, 50, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL press_r%0dc%0d_unlock got timeout, required scanning", r, c);
      end
      checks++;
      if (events - ev0 != 1) begin
         failures++;
         $display("FAIL press_r%0dc%0d_event_count got %0d, required 1", r, c, events - ev0);
      end
   endtask

   task automatic test_key_codes;
      press_key(3, 1, 4'h0);
      press_key(3, 3, 4'hD);
      press_key(0, 3, 4'hA);
      press_key(2, 0, 4'h7);
   endtask

   task automatic test_reset_mid_lock;
      bit ok;
      int ev0;
      key_mask[2] = 4'b0100;
      wait_scan(1'b0, 200, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL midlock_lock got timeout, required lock");
      end
      ev0       = events;
      key_valid = 1'b1;
      rst_n     = 1'b0;
      @(negedge clk);
      checks++;
      if ({row_n, key_pressed, row_idx, col_idx, key_event, key_code, scanning} !==
          {4'b1110, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1}) begin
         failures++;
         $display("FAIL midlock_reset got %b, required %b",
                  {row_n, key_pressed, row_idx, col_idx, key_event, key_code, scanning},
                  {4'b1110, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1});
      end
      rst_n       = 1'b1;
      key_mask[2] = 4'h0;
      repeat (10) @(negedge clk);
      key_valid = 1'b0;
      checks++;
      if (events != ev0) begin
         failures++;
         $display("FAIL midlock_no_event got %0d events, required 0", events - ev0);
      end
   endtask

   task automatic test_multi_key;
`ifdef MULTI_KEY_REJECT_EN
      bit locked  = 1'b0;
      bit saw_adv = 1'b0;
      logic [3:0] prev;
      key_mask[0] = 4'b0011;
      prev = row_n;
      repeat (60) begin
         @(negedge clk);
         if (scanning !== 1'b1) locked = 1'b1;
         if (prev == 4'b1110 && row_n == 4'b1101) saw_adv = 1'b1;
         prev = row_n;
      end
      key_mask[0] = 4'h0;
      checks++;
      if (locked) begin
         failures++;
         $display("FAIL multi_key_reject got lock, required no lock");
      end
      checks++;
      if (!saw_adv) begin
         failures++;
         $display("FAIL multi_key_advance got no 1110->1101, required advance");
      end
`else
      bit ok;
      key_mask[0] = 4'b0011;
      wait_scan(1'b0, 200, ok);
      checks++;
      if (!ok || {row_idx, col_idx} !== {4'b0001, 4'b0001}) begin
         failures++;
         $display("FAIL multi_key_lowest got ok=%0d %b, required 1 %b", ok, {row_idx, col_idx},
                  {4'b0001, 4'b0001});
      end
      exp_q.push_back(4'h1);
      key_valid = 1'b1;
      repeat (3) @(negedge clk);
      key_valid   = 1'b0;
      key_mask[0] = 4'h0;
      wait_scan(1'b1, 50, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL multi_key_unlock got timeout, required scanning");
      end
`endif
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_press_row1();
      test_bounce();
      test_release();
      test_key_codes();
      test_reset_mid_lock();
      test_multi_key();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drained got %0d pending, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
